// File: rtl/cache_response_distributor_pkg.sv
// Shared types for the cache response return path.
// The optional ID check is CACHE_RESPONSE_DISTRIBUTOR_ID_CHECK_EN.
package GLAY_MEMORY_PKG;

    localparam int CACHE_RESP_FIFO_DEPTH_DEFAULT = 16;
    localparam int CACHE_RESP_DATA_W_DEFAULT = 512;
    localparam int CACHE_RESP_ID_W_DEFAULT = 2;

    typedef enum logic [1:0] {
        RESP_DIST_RESET,
        RESP_DIST_SETUP,
        RESP_DIST_IDLE,
        RESP_DIST_SEND
    } cache_response_distributor_state;

    typedef struct packed {
        logic [CACHE_RESP_ID_W_DEFAULT-1:0]   id;
        logic [CACHE_RESP_DATA_W_DEFAULT-1:0] data;
    } CacheResponseEntry;

endpackage

// File: rtl/cache_response_distributor_if.sv
// Cache-side input, per-requestor output and status bundle.
// id_error ports exist only with CACHE_RESPONSE_DISTRIBUTOR_ID_CHECK_EN.
interface cache_response_distributor_if #(
    parameter int NUM_MEMORY_REQUESTOR = 2,
    parameter int DATA_W = 512,
    parameter int ID_W = 2
);
    logic                            cache_resp_in_valid;
    logic [DATA_W-1:0]               cache_resp_in_data;
    logic [ID_W-1:0]                 cache_resp_in_id;
    logic                            cache_resp_in_ready;
    logic [NUM_MEMORY_REQUESTOR-1:0] mem_resp_out_valid;
    logic [DATA_W-1:0]               mem_resp_out_data;
    logic [ID_W-1:0]                 mem_resp_out_id;
    logic [NUM_MEMORY_REQUESTOR-1:0] mem_resp_out_ready;
    logic                            cache_resp_done;
    logic                            fifo_setup_signal;
    logic                            resp_fifo_empty;
    logic                            resp_fifo_full;
`ifdef CACHE_RESPONSE_DISTRIBUTOR_ID_CHECK_EN
    logic                            id_error;
    logic [15:0]                     id_error_count;

    modport master (
        output cache_resp_in_valid, cache_resp_in_data,
        output cache_resp_in_id, mem_resp_out_ready,
        input  cache_resp_in_ready, mem_resp_out_valid,
        input  mem_resp_out_data, mem_resp_out_id,
        input  cache_resp_done, fifo_setup_signal,
        input  resp_fifo_empty, resp_fifo_full,
        input  id_error, id_error_count
    );

    modport slave (
        input  cache_resp_in_valid, cache_resp_in_data,
        input  cache_resp_in_id, mem_resp_out_ready,
        output cache_resp_in_ready, mem_resp_out_valid,
        output mem_resp_out_data, mem_resp_out_id,
        output cache_resp_done, fifo_setup_signal,
        output resp_fifo_empty, resp_fifo_full,
        output id_error, id_error_count
    );
`else
    modport master (
        output cache_resp_in_valid, cache_resp_in_data,
        output cache_resp_in_id, mem_resp_out_ready,
        input  cache_resp_in_ready, mem_resp_out_valid,
        input  mem_resp_out_data, mem_resp_out_id,
        input  cache_resp_done, fifo_setup_signal,
        input  resp_fifo_empty, resp_fifo_full
    );

    modport slave (
        input  cache_resp_in_valid, cache_resp_in_data,
        input  cache_resp_in_id, mem_resp_out_ready,
        output cache_resp_in_ready, mem_resp_out_valid,
        output mem_resp_out_data, mem_resp_out_id,
        output cache_resp_done, fifo_setup_signal,
        output resp_fifo_empty, resp_fifo_full
    );
`endif

endinterface

// File: rtl/cache_response_distributor_fifo.sv
// Synchronous response FIFO with registered empty/full and
// a look-ahead occupancy used for the upstream ready.
module cache_response_fifo #(
    parameter int WIDTH = 514,
    parameter int DEPTH = 16
) (
    input  logic                   ap_clk,
    input  logic                   areset,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic [$clog2(DEPTH):0] count_next,
    output logic                   empty,
    output logic                   full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_wr;
    logic             do_rd;

    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr];
    assign count_next = count + CW'(do_wr) - CW'(do_rd);

    always_ff @(posedge ap_clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count_next;
            empty <= (count_next == '0);
            full  <= (count_next == CW'(DEPTH));
        end
    end

endmodule

// File: rtl/cache_response_distributor.sv
// Buffers cache read responses and routes them in order to requestors.
// CACHE_RESPONSE_DISTRIBUTOR_ID_CHECK_EN drops out-of-range IDs.
module cache_response_distributor
    import GLAY_MEMORY_PKG::*;
#(
    parameter int NUM_MEMORY_REQUESTOR = 2,
    parameter int DATA_W = 512,
    parameter int ID_W = 2,
    parameter int RESP_FIFO_DEPTH = CACHE_RESP_FIFO_DEPTH_DEFAULT,
    parameter int SETUP_CYCLES = 4
) (
    input logic                      ap_clk,
    input logic                      areset,
    cache_response_distributor_if.slave bus
);

    localparam int NR = NUM_MEMORY_REQUESTOR;
    localparam int EW = ID_W + DATA_W;
    localparam int CW = $clog2(RESP_FIFO_DEPTH) + 1;
    localparam int SW = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;

    cache_response_distributor_state state;

    logic [SW-1:0]     setup_cnt;
    logic [EW-1:0]     head;
    logic [ID_W-1:0]   head_id;
    logic [DATA_W-1:0] head_data;
    logic [CW-1:0]     occ_next;
    logic              fifo_empty;
    logic              fifo_full;
    logic              accept;
    logic              id_ok;
    logic              wr_en;
    logic              rd_en;
    logic              handshake;
    logic              running_next;

    logic [NR-1:0]     out_valid;
    logic [DATA_W-1:0] out_data;
    logic [ID_W-1:0]   out_id;
    logic              in_ready;
    logic              done;
    logic              setup;

    function automatic logic [NR-1:0] dest_onehot(
        input logic [ID_W-1:0] id
    );
        dest_onehot = '0;
        for (int i = 0; i < NR; i++) begin
            dest_onehot[i] = ((int'(id) % NR) == i);
        end
    endfunction

    assign {head_id, head_data} = head;
    assign accept = bus.cache_resp_in_valid && in_ready;
`ifdef CACHE_RESPONSE_DISTRIBUTOR_ID_CHECK_EN
    assign id_ok = (int'(bus.cache_resp_in_id) < NR);
`else
    assign id_ok = 1'b1;
`endif
    assign wr_en = accept && id_ok;

    // Non-selected readies are masked out by the one-hot valid.
    assign handshake = |(out_valid & bus.mem_resp_out_ready);

    assign rd_en = !fifo_empty &&
                   ((state == RESP_DIST_IDLE) ||
                    (state == RESP_DIST_SEND && handshake));

    assign running_next = (state == RESP_DIST_IDLE) ||
                          (state == RESP_DIST_SEND) ||
                          (state == RESP_DIST_SETUP &&
                           setup_cnt == '0);

    cache_response_fifo #(
        .WIDTH (EW),
        .DEPTH (RESP_FIFO_DEPTH)
    ) u_fifo (
        .ap_clk     (ap_clk),
        .areset     (areset),
        .wr_en      (wr_en),
        .wr_data    ({bus.cache_resp_in_id, bus.cache_resp_in_data}),
        .rd_en      (rd_en),
        .rd_data    (head),
        .count_next (occ_next),
        .empty      (fifo_empty),
        .full       (fifo_full)
    );

    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) begin
            state     <= RESP_DIST_RESET;
            setup_cnt <= '0;
            out_valid <= '0;
            out_data  <= '0;
            out_id    <= '0;
            done      <= 1'b0;
            setup     <= 1'b1;
            in_ready  <= 1'b0;
        end else begin
            done <= handshake;
            unique case (state)
                RESP_DIST_RESET: begin
                    state     <= RESP_DIST_SETUP;
                    setup_cnt <= SW'(SETUP_CYCLES - 1);
                end
                RESP_DIST_SETUP: begin
                    if (setup_cnt == '0) begin
                        state <= RESP_DIST_IDLE;
                    end else begin
                        setup_cnt <= setup_cnt - SW'(1);
                    end
                end
                RESP_DIST_IDLE: begin
                    if (rd_en) begin
                        state     <= RESP_DIST_SEND;
                        out_valid <= dest_onehot(head_id);
                        out_data  <= head_data;
                        out_id    <= head_id;
                    end
                end
                RESP_DIST_SEND: begin
                    if (rd_en) begin
                        out_valid <= dest_onehot(head_id);
                        out_data  <= head_data;
                        out_id    <= head_id;
                    end else if (handshake) begin
                        out_valid <= '0;
                        state     <= RESP_DIST_IDLE;
                    end
                end
                default: state <= RESP_DIST_RESET;
            endcase
            // One free slot stays in reserve so a write never overflows.
            setup    <= !running_next;
            in_ready <= running_next &&
                        (occ_next <= CW'(RESP_FIFO_DEPTH - 2));
        end
    end

`ifdef CACHE_RESPONSE_DISTRIBUTOR_ID_CHECK_EN
    logic        id_error;
    logic [15:0] id_error_count;

    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) begin
            id_error       <= 1'b0;
            id_error_count <= '0;
        end else if (accept && !id_ok) begin
            id_error <= 1'b1;
            if (id_error_count != 16'hFFFF) begin
                id_error_count <= id_error_count + 16'd1;
            end
        end
    end

    assign bus.id_error       = id_error;
    assign bus.id_error_count = id_error_count;
`endif

    assign bus.cache_resp_in_ready = in_ready;
    assign bus.mem_resp_out_valid  = out_valid;
    assign bus.mem_resp_out_data   = out_data;
    assign bus.mem_resp_out_id     = out_id;
    assign bus.cache_resp_done     = done;
    assign bus.fifo_setup_signal   = setup;
    assign bus.resp_fifo_empty     = fifo_empty;
    assign bus.resp_fifo_full      = fifo_full;

endmodule

// File: tb/tb_cache_response_distributor.sv
// Randomised bench for cache_response_distributor with a queue-based
// reference model compared every cycle plus directed literal checks.
module tb_cache_response_distributor;

    localparam int N  = 2;
    localparam int DW = 512;
    localparam int IW = 2;
    localparam int D  = 16;
    localparam int SC = 4;

    logic ap_clk = 1'b0;
    logic areset = 1'b1;

    always #5 ap_clk = ~ap_clk;

    cache_response_distributor_if #(
        .NUM_MEMORY_REQUESTOR (N),
        .DATA_W               (DW),
        .ID_W                 (IW)
    ) bus ();

    cache_response_distributor #(
        .NUM_MEMORY_REQUESTOR (N),
        .DATA_W               (DW),
        .ID_W                 (IW),
        .RESP_FIFO_DEPTH      (D),
        .SETUP_CYCLES         (SC)
    ) dut (
        .ap_clk (ap_clk),
        .areset (areset),
        .bus    (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom();
        return d;
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
    } ent_t;

    ent_t q[$];
    ent_t slot;
    bit   slot_v     = 0;
    bit   m_in_reset = 1;
    bit   m_running  = 0;
    int   m_setup_left = 0;
    bit   m_done  = 0;
    bit   m_ready = 0;
    bit   m_err   = 0;
    int   m_err_cnt = 0;

    task automatic model_reset();
        q.delete();
        slot_v = 0;
        m_in_reset = 1;
        m_running = 0;
        m_setup_left = 0;
        m_done = 0;
        m_ready = 0;
        m_err = 0;
        m_err_cnt = 0;
    endtask

    task automatic model_step();
        bit   acc;
        bit   hs;
        bit   was_running;
        ent_t e;
        acc = bus.cache_resp_in_valid && m_ready;
        hs  = slot_v && bus.mem_resp_out_ready[int'(slot.id) % N];
        m_done = hs;
        was_running = m_running;
        if (m_in_reset) begin
            m_in_reset = 0;
            m_setup_left = SC;
        end else if (!m_running) begin
            m_setup_left--;
            if (m_setup_left == 0) m_running = 1;
        end
        if (was_running && (!slot_v || hs)) begin
            if (q.size() > 0) begin
                slot = q.pop_front();
                slot_v = 1;
            end else begin
                slot_v = 0;
            end
        end
        if (acc) begin
            e.id = bus.cache_resp_in_id;
            e.data = bus.cache_resp_in_data;
`ifdef CACHE_RESPONSE_DISTRIBUTOR_ID_CHECK_EN
            if (int'(e.id) >= N) begin
                m_err = 1;
                if (m_err_cnt < 65535) m_err_cnt++;
            end else begin
                q.push_back(e);
            end
`else
            q.push_back(e);
`endif
        end
        m_ready = m_running && (q.size() <= D - 2);
    endtask

    task automatic compare();
        logic [N-1:0] ev;
        ev = '0;
        if (slot_v) ev[int'(slot.id) % N] = 1'b1;
        chk("out_valid", bus.mem_resp_out_valid, ev);
        if (slot_v) begin
            chk("out_data", bus.mem_resp_out_data, slot.data);
            chk("out_id", bus.mem_resp_out_id, slot.id);
        end
        if (areset) begin
            chk("rst_data", bus.mem_resp_out_data, 0);
            chk("rst_id", bus.mem_resp_out_id, 0);
        end
        chk("in_ready", bus.cache_resp_in_ready, m_ready);
        chk("done", bus.cache_resp_done, m_done);
        chk("setup", bus.fifo_setup_signal, !m_running);
        chk("empty", bus.resp_fifo_empty, q.size() == 0);
        chk("full", bus.resp_fifo_full, q.size() == D);
`ifdef CACHE_RESPONSE_DISTRIBUTOR_ID_CHECK_EN
        chk("id_error", bus.id_error, m_err);
        chk("id_error_count", bus.id_error_count, m_err_cnt);
`endif
    endtask

    initial begin
        forever begin
            @(posedge ap_clk);
            if (areset) model_reset();
            else model_step();
            #1;
            compare();
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle_inputs();
        bus.cache_resp_in_valid = 1'b0;
        bus.cache_resp_in_id    = '0;
        bus.cache_resp_in_data  = '0;
    endtask

    task automatic do_reset();
        @(negedge ap_clk);
        areset = 1'b1;
        idle_inputs();
        repeat (2) @(negedge ap_clk);
        areset = 1'b0;
        repeat (SC + 3) @(posedge ap_clk);
    endtask

    int cnt;
    int vcnt;
    int dcnt;
    int run;
    int maxrun;
    int acc;

    initial begin
        idle_inputs();
        bus.mem_resp_out_ready = '0;
        repeat (3) @(posedge ap_clk);
        @(negedge ap_clk);
        chk("rst_setup", bus.fifo_setup_signal, 1);
        chk("rst_empty", bus.resp_fifo_empty, 1);
        chk("rst_ready", bus.cache_resp_in_ready, 0);
        chk("rst_valid", bus.mem_resp_out_valid, 0);
        areset = 1'b0;

        // setup window
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge ap_clk);
            #1;
            if (bus.fifo_setup_signal) cnt++;
            else break;
        end
        chk("setup_len", cnt, 4);
        chk("ready_after_setup", bus.cache_resp_in_ready, 1);
        chk("valid_after_setup", bus.mem_resp_out_valid, 0);

        // single response
        @(negedge ap_clk);
        bus.cache_resp_in_valid = 1'b1;
        bus.cache_resp_in_id    = 2'd1;
        bus.cache_resp_in_data  = DW'(8'hA5);
        bus.mem_resp_out_ready  = 2'b10;
        @(posedge ap_clk);
        @(negedge ap_clk);
        idle_inputs();
        @(posedge ap_clk);
        #1;
        chk("single_valid", bus.mem_resp_out_valid, 2'b10);
        chk("single_data", bus.mem_resp_out_data, 8'hA5);
        chk("single_done_early", bus.cache_resp_done, 0);
        @(posedge ap_clk);
        #1;
        chk("single_done", bus.cache_resp_done, 1);
        chk("single_valid_clr", bus.mem_resp_out_valid, 0);
        @(posedge ap_clk);
        #1;
        chk("single_done_once", bus.cache_resp_done, 0);

        // back-to-back
        vcnt = 0; dcnt = 0; run = 0; maxrun = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge ap_clk);
            bus.mem_resp_out_ready = 2'b11;
            if (i < 8) begin
                bus.cache_resp_in_valid = 1'b1;
                bus.cache_resp_in_id    = IW'(i % 2);
                bus.cache_resp_in_data  = rand_data();
            end else begin
                idle_inputs();
            end
            @(posedge ap_clk);
            #1;
            if (bus.mem_resp_out_valid != 0) begin
                vcnt++;
                run++;
                if (run > maxrun) maxrun = run;
            end else begin
                run = 0;
            end
            if (bus.cache_resp_done) dcnt++;
        end
        chk("b2b_outputs", vcnt, 8);
        chk("b2b_consecutive", maxrun, 8);
        chk("b2b_done", dcnt, 8);

        // backpressure
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge ap_clk);
            bus.mem_resp_out_ready  = 2'b00;
            bus.cache_resp_in_valid = 1'b1;
            bus.cache_resp_in_id    = IW'($urandom_range(0, 1));
            bus.cache_resp_in_data  = rand_data();
            if (bus.cache_resp_in_ready) acc++;
        end
        @(negedge ap_clk);
        idle_inputs();
        chk("bp_accepted", acc, 16);
        chk("bp_ready_low", bus.cache_resp_in_ready, 0);
        chk("bp_not_full", bus.resp_fifo_full, 0);
        chk("bp_not_empty", bus.resp_fifo_empty, 0);
        bus.mem_resp_out_ready = 2'b11;
        dcnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge ap_clk);
            #1;
            if (bus.cache_resp_done) dcnt++;
        end
        chk("bp_drain_done", dcnt, 16);
        chk("bp_drain_empty", bus.resp_fifo_empty, 1);

        // async reset mid-SEND with 5 buffered
        for (int i = 0; i < 6; i++) begin
            @(negedge ap_clk);
            bus.mem_resp_out_ready  = 2'b00;
            bus.cache_resp_in_valid = 1'b1;
            bus.cache_resp_in_id    = IW'($urandom_range(0, 1));
            bus.cache_resp_in_data  = rand_data();
        end
        @(negedge ap_clk);
        idle_inputs();
        repeat (2) @(posedge ap_clk);
        @(posedge ap_clk);
        #3;
        areset = 1'b1;
        #1;
        chk("arst_valid", bus.mem_resp_out_valid, 0);
        chk("arst_done", bus.cache_resp_done, 0);
        chk("arst_setup", bus.fifo_setup_signal, 1);
        chk("arst_empty", bus.resp_fifo_empty, 1);
        chk("arst_ready", bus.cache_resp_in_ready, 0);
        repeat (2) @(negedge ap_clk);
        areset = 1'b0;
        bus.mem_resp_out_ready = 2'b11;
        vcnt = 0; dcnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge ap_clk);
            #1;
            if (bus.mem_resp_out_valid != 0) vcnt++;
            if (bus.cache_resp_done) dcnt++;
        end
        chk("arst_no_stale", vcnt, 0);
        chk("arst_no_done", dcnt, 0);
        chk("arst_fifo_empty", bus.resp_fifo_empty, 1);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            @(negedge ap_clk);
            bus.cache_resp_in_valid = ($urandom_range(0, 99) < 60);
            bus.cache_resp_in_id    = IW'($urandom_range(0, 3));
            bus.cache_resp_in_data  = rand_data();
            if ((i / 300) % 2 == 1)
                bus.mem_resp_out_ready = N'($urandom_range(0, 3)) &
                                         N'($urandom_range(0, 3));
            else
                bus.mem_resp_out_ready = N'($urandom_range(0, 3));
            if (i == 2000) begin
                @(posedge ap_clk);
                #3;
                areset = 1'b1;
                @(negedge ap_clk);
                @(negedge ap_clk);
                areset = 1'b0;
            end
        end
        @(negedge ap_clk);
        idle_inputs();
        bus.mem_resp_out_ready = 2'b11;
        repeat (40) @(posedge ap_clk);
        #1;
        chk("rand_drained", bus.resp_fifo_empty, 1);

`ifdef CACHE_RESPONSE_DISTRIBUTOR_ID_CHECK_EN
        do_reset();
        @(negedge ap_clk);
        bus.mem_resp_out_ready  = 2'b11;
        bus.cache_resp_in_valid = 1'b1;
        bus.cache_resp_in_id    = 2'd3;
        bus.cache_resp_in_data  = DW'(16'hDEAD);
        @(negedge ap_clk);
        bus.cache_resp_in_id    = 2'd0;
        bus.cache_resp_in_data  = DW'(16'h1234);
        @(negedge ap_clk);
        idle_inputs();
        vcnt = 0; dcnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge ap_clk);
            #1;
            if (bus.mem_resp_out_valid != 0) begin
                vcnt++;
                chk("idchk_valid", bus.mem_resp_out_valid, 2'b01);
                chk("idchk_data", bus.mem_resp_out_data, 16'h1234);
            end
            if (bus.cache_resp_done) dcnt++;
        end
        chk("idchk_outputs", vcnt, 1);
        chk("idchk_done", dcnt, 1);
        chk("idchk_error", bus.id_error, 1);
        chk("idchk_count", bus.id_error_count, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_response_distributor.md
Name: cache_response_distributor

Overview:
- Return path of the cache request generator. Accepts read responses from the GLay cache and buffers them in an internal response FIFO.
- Routes each response, by requestor ID, to one of NUM_MEMORY_REQUESTOR engine ports using a valid/ready handshake.
- Pulses cache_resp_done once per delivered response. This pulse drives the generator's cache_resp_ready / outstanding-transaction credit return.

Parameters:
- NUM_MEMORY_REQUESTOR, 2, number of requestor ports.
- DATA_W, 512, response data width.
- ID_W, 2, requestor-ID field width; must be ≥ $clog2(NUM_MEMORY_REQUESTOR).
- RESP_FIFO_DEPTH, 16, response FIFO entries; power of 2, ≥ 4.
- SETUP_CYCLES, 4, cycles fifo_setup_signal stays high after reset.

Ports:
- ap_clk  in  1  sole clock; all logic is posedge.
- areset  in  1  reset, asynchronous, active-high.
- cache_resp_in_valid  in  1  cache response valid.
- cache_resp_in_data  in  DATA_W  response read data.
- cache_resp_in_id  in  ID_W  destination requestor index.
- cache_resp_in_ready  out  1  distributor can accept a response (registered).
- mem_resp_out_valid  out  NUM_MEMORY_REQUESTOR  one-hot per-requestor valid.
- mem_resp_out_data  out  DATA_W  data, shared by all requestors.
- mem_resp_out_id  out  ID_W  ID of the current output.
- mem_resp_out_ready  in  NUM_MEMORY_REQUESTOR  per-requestor ready.
- cache_resp_done  out  1  one-cycle pulse per delivered response.
- fifo_setup_signal  out  1  high while the block is initialising.
- resp_fifo_empty  out  1  FIFO occupancy == 0, registered.
- resp_fifo_full  out  1  FIFO occupancy == RESP_FIFO_DEPTH, registered.

Behaviour:
- Reset values, while areset is high:
  - All outputs 0, except fifo_setup_signal = 1 and resp_fifo_empty = 1.
  - FIFO pointers and occupancy cleared.
  - State = RESP_DIST_RESET.
  - Reset asserted mid-operation discards all buffered and in-flight responses; no done pulses are issued for them.
- State machine:
  - RESP_DIST_RESET → RESP_DIST_SETUP on the first edge after areset deasserts.
  - SETUP holds fifo_setup_signal = 1 for SETUP_CYCLES cycles, using a down-counter, then → RESP_DIST_IDLE.
  - IDLE → RESP_DIST_SEND when the FIFO is non-empty; the head is loaded into the output register on that edge.
  - SEND holds valid and data stable until mem_resp_out_ready[id] == 1. On the handshake edge:
    - FIFO non-empty → load the next head and stay in SEND (back-to-back, 1 response/cycle).
    - FIFO empty → IDLE.
- Input acceptance:
  - A response is written when cache_resp_in_valid && cache_resp_in_ready are both high at a rising edge.
  - cache_resp_in_ready is 0 in RESET and SETUP.
  - Otherwise it is registered as (occupancy after this edge ≤ RESP_FIFO_DEPTH−2). This leaves one slot of margin, so overflow cannot occur.
- Latency:
  - A response accepted at edge T into an empty FIFO in IDLE is written at T, loaded into the output at T+1, and is visible with mem_resp_out_valid during the cycle after T+1.
  - cache_resp_done pulses in the cycle after the output handshake edge, exactly once per handshake.
- Output encoding:
  - mem_resp_out_valid is exactly one-hot or zero: bit [id] is set when valid.
  - mem_resp_out_ready bits of non-selected requestors are ignored.
  - Head-of-line blocking is intentional: strict FIFO order is kept across requestors.
- Simultaneous events:
  - Write and read on the same edge leave occupancy unchanged and are legal at any occupancy, including a write into a FIFO that the same edge empties.
  - A write into an empty FIFO in the same cycle as a SEND handshake is loaded on the next edge; there is no bypass.
- Pointers are $clog2(RESP_FIFO_DEPTH) bits and wrap modulo depth. Occupancy is $clog2(RESP_FIFO_DEPTH)+1 bits.

Optional Feature:
- Macro: CACHE_RESPONSE_DISTRIBUTOR_ID_CHECK_EN.
- When defined:
  - An accepted response with cache_resp_in_id ≥ NUM_MEMORY_REQUESTOR is dropped (not written).
  - Sticky output id_error (1 bit, reset 0) is set.
  - 16-bit saturating output id_error_count increments on each drop.
  - No done pulse is generated for a dropped response.
- When undefined: those ports do not exist, and the ID is taken modulo NUM_MEMORY_REQUESTOR (low bits) with no check.

Decomposition:
- GLAY_MEMORY_PKG holds:
  - enum cache_response_distributor_state {RESP_DIST_RESET, RESP_DIST_SETUP, RESP_DIST_IDLE, RESP_DIST_SEND};
  - packed struct CacheResponseEntry {id, data};
  - constant CACHE_RESP_FIFO_DEPTH_DEFAULT = 16.
- Natural sub-module: cache_response_fifo, a synchronous FIFO with occupancy, full and empty, instantiated once.

Test Plan:
- Reset release: fifo_setup_signal stays 1 for 4 cycles after the RESET cycle. cache_resp_in_ready rises the cycle after SETUP exits; all valids are 0.
- Single response: id = 1, data = 0xA5 at edge T, ready[1] = 1 → mem_resp_out_valid = 2'b10 visible after T+1 with data 0xA5. cache_resp_done pulses once, in the cycle after the handshake.
- Back-to-back: 8 responses with alternating id 0/1 and both readies high → 8 outputs in order on consecutive cycles and 8 done pulses.
- Backpressure: mem_resp_out_ready = 0 while 20 responses are offered → ready drops at occupancy 15, no overflow, resp_fifo_full never asserts. On releasing ready, all accepted responses drain in order.
- Async reset mid-SEND with 5 buffered: outputs clear immediately with no done pulse. After SETUP the FIFO is empty and no stale response appears.
- With the ID-check macro defined: inject id = 3 → dropped, id_error = 1, id_error_count = 1, no output. The following id = 0 response is delivered normally.
